// File: rtl/key_event_ctrl.sv
// Multi-key debouncer / event front-end.
// All keys share one millisecond time base. Each key is debounced and produces
// press, release and long-press events. A round-robin scheduler moves these events
// into a small first-word-fall-through FIFO, which the consumer drains with valid/ready.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   key_i         raw key pins (asynchronous)
//   key_o         debounced level per key, 1 = pressed
//   evt_valid     FIFO head holds an event
//   evt_ready     consumer accepts the head event
//   evt_key       key index of the head event
//   evt_type      head event type: 01 press, 10 release, 11 long
//   overflow      sticky flag, set when an event was dropped
//   clr_ovf       synchronous clear of overflow
module key_event_ctrl #(
    parameter int unsigned NUM_KEYS       = 4,
    parameter int unsigned TICK_CNT       = 50_000,
    parameter int unsigned DEB_MS         = 20,
    parameter int unsigned LONG_MS        = 1000,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter bit          KEY_ACTIVE_LOW = 1'b1,
    localparam int unsigned IDX_W         = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_i,
    output logic [NUM_KEYS-1:0] key_o,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [IDX_W-1:0]    evt_key,
    output logic [1:0]          evt_type,
    output logic                overflow,
    input  logic                clr_ovf
);
    localparam int unsigned PRE_W  = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
    localparam int unsigned DEB_W  = $clog2(DEB_MS + 1);
    localparam int unsigned LONG_W = $clog2(LONG_MS + 1);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENT_W  = IDX_W + 2;
    localparam logic [NUM_KEYS-1:0] SYNC_RST = {NUM_KEYS{KEY_ACTIVE_LOW}};

    localparam logic [1:0] EVT_PRESS = 2'b01;
    localparam logic [1:0] EVT_REL   = 2'b10;
    localparam logic [1:0] EVT_LONG  = 2'b11;

    logic [NUM_KEYS-1:0] sync1_q, sync2_q, raw;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic                tick;
    logic [DEB_W-1:0]    deb_q [NUM_KEYS];
    logic [DEB_W-1:0]    deb_d [NUM_KEYS];
    logic [LONG_W-1:0]   long_q [NUM_KEYS];
    logic [LONG_W-1:0]   long_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] key_q, key_d;
    logic [NUM_KEYS-1:0] pend_q, pend_d;
    logic [1:0]          ptype_q [NUM_KEYS];
    logic [1:0]          ptype_d [NUM_KEYS];
    logic                ovf_q, ovf_d, drop;
    logic [IDX_W-1:0]    rr_q, rr_d, gnt_idx;
    logic                grant, found;
    logic [1:0]          gnt_type;
    logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_q, rd_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, full, pop;

    // Synchronised pins, normalised so that 1 = pressed
    assign raw = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Shared time base
    assign tick  = (pre_q == PRE_W'(TICK_CNT - 1));
    assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

    // Per-key debounce, long-press detection and pending-slot update
    always_comb begin
        logic       ev;
        logic [1:0] ev_type;
        key_d  = key_q;
        pend_d = pend_q;
        drop   = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            deb_d[k]   = deb_q[k];
            long_d[k]  = long_q[k];
            ptype_d[k] = ptype_q[k];
        end
        if (grant) pend_d[gnt_idx] = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            ev      = 1'b0;
            ev_type = EVT_PRESS;
            if (raw[k] == key_q[k]) begin
                deb_d[k] = '0;
            end else if (tick) begin
                if (deb_q[k] == DEB_W'(DEB_MS - 1)) begin
                    key_d[k] = ~key_q[k];
                    deb_d[k] = '0;
                    ev       = 1'b1;
                    ev_type  = key_q[k] ? EVT_REL : EVT_PRESS;
                end else begin
                    deb_d[k] = deb_q[k] + DEB_W'(1);
                end
            end
            // Long counter saturates, so it fires once per press; a release on the
            // same tick takes priority.
            if (!key_q[k]) begin
                long_d[k] = '0;
            end else if (tick && (long_q[k] != LONG_W'(LONG_MS))) begin
                long_d[k] = long_q[k] + LONG_W'(1);
                if ((long_q[k] == LONG_W'(LONG_MS - 1)) && !ev) begin
                    ev      = 1'b1;
                    ev_type = EVT_LONG;
                end
            end
            // A slot that is occupied (even if being granted now) drops the new event
            if (ev) begin
                if (pend_q[k]) begin
                    drop = 1'b1;
                end else begin
                    pend_d[k]  = 1'b1;
                    ptype_d[k] = ev_type;
                end
            end
        end
    end

    // Round-robin grant: first occupied slot at or after rr_q
    always_comb begin
        int unsigned idx;
        logic [IDX_W-1:0] cand;
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            idx  = (32'(rr_q) + i) % NUM_KEYS;
            cand = IDX_W'(idx);
            if (!found && pend_q[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        grant    = found && !full;
        gnt_type = ptype_q[gnt_idx];
        rr_d     = grant ? IDX_W'((32'(gnt_idx) + 32'd1) % NUM_KEYS) : rr_q;
    end

    // FIFO bookkeeping
    assign full = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign pop  = valid_q && evt_ready;

    always_comb begin
        cnt_d = cnt_q;
        case ({grant, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Sticky overflow; a drop in the same cycle beats the clear
    assign ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= SYNC_RST;
            sync2_q <= SYNC_RST;
            pre_q   <= '0;
            key_q   <= '0;
            pend_q  <= '0;
            rr_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                deb_q[k]   <= '0;
                long_q[k]  <= '0;
                ptype_q[k] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            pre_q   <= pre_d;
            key_q   <= key_d;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            valid_q <= (cnt_d != '0);
            ovf_q   <= ovf_d;
            for (int k = 0; k < NUM_KEYS; k++) begin
                deb_q[k]   <= deb_d[k];
                long_q[k]  <= long_d[k];
                ptype_q[k] <= ptype_d[k];
            end
            if (grant) begin
                mem_q[wr_q] <= {gnt_idx, gnt_type};
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (pop) rd_q <= rd_q + PTR_W'(1);
        end
    end

    assign key_o               = key_q;
    assign evt_valid           = valid_q;
    assign {evt_key, evt_type} = mem_q[rd_q];
    assign overflow            = ovf_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with a 10-cycle tick, 3-tick debounce, 8-tick long press.
module tb_key_event_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_i;
    logic [3:0] key_o;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_key;
    logic [1:0] evt_type;
    logic       overflow;
    logic       clr_ovf;

    int n_total;
    int n_bad;
    int cyc = 0;
    int m, m2, r, f;

    logic [1:0] ev_k [$];
    logic [1:0] ev_t [$];
    int         ev_c [$];
    int         rise_cnt [4];
    int         rise_cyc [4];
    logic [3:0] key_prev = 4'h0;

    key_event_ctrl #(
        .NUM_KEYS      (4),
        .TICK_CNT      (10),
        .DEB_MS        (3),
        .LONG_MS       (8),
        .FIFO_DEPTH    (4),
        .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_i    (key_i),
        .key_o    (key_o),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_key  (evt_key),
        .evt_type (evt_type),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    // Edges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Record key_o rises and consumed events
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (key_o[k] && !key_prev[k]) begin
                    rise_cnt[k] = rise_cnt[k] + 1;
                    rise_cyc[k] = cyc;
                end
            end
            if (evt_valid && evt_ready) begin
                ev_k.push_back(evt_key);
                ev_t.push_back(evt_type);
                ev_c.push_back(cyc);
            end
        end
        key_prev = key_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        ev_k.delete();
        ev_t.delete();
        ev_c.delete();
        for (int k = 0; k < 4; k++) begin
            rise_cnt[k] = 0;
            rise_cyc[k] = -1;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        key_i     = 4'hF;
        evt_ready = 1'b1;
        clr_ovf   = 1'b0;
        step(3);
        rst_n = 1'b1;
        clear_mon();
    endtask

    // Edge at which key_o toggles when the pin changed right after edge m:
    // raw visible from edge m+3, ticks land on multiples of 10, 3 ticks needed.
    function automatic int t_settle(input int mm);
        return ((mm + 12) / 10) * 10 + 20;
    endfunction

    function automatic logic [31:0] w(input int k, input int t);
        return 32'(k * 4 + t);
    endfunction

    function automatic logic [31:0] ev_word(input int i);
        if (i < ev_k.size()) return 32'({ev_k[i], ev_t[i]});
        return 32'hFF;
    endfunction

    function automatic logic [31:0] ev_cyc(input int i);
        if (i < ev_c.size()) return 32'(ev_c[i]);
        return 32'hFFFF_FFFF;
    endfunction

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        key_i   = 4'hF;
        evt_ready = 1'b1;
        clr_ovf = 1'b0;
        do_reset();

        // reset state
        chk("rst_key_o", 32'(key_o), 32'h0);
        chk("rst_valid", 32'(evt_valid), 32'h0);
        chk("rst_key", 32'(evt_key), 32'h0);
        chk("rst_type", 32'(evt_type), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);

        // bounce on key0, final level pressed
        m = 0;
        for (int i = 0; i < 15; i++) begin
            key_i[0] = ~key_i[0];
            m = cyc;
            step(4);
        end
        r = t_settle(m);
        step(r + 10 - cyc);
        chk("b_rises", 32'(rise_cnt[0]), 32'd1);
        chk("b_rise_cyc", 32'(rise_cyc[0]), 32'(r));
        chk("b_nev", 32'(ev_k.size()), 32'd1);
        chk("b_ev0", ev_word(0), w(0, 1));
        chk("b_ev0_cyc", ev_cyc(0), 32'(r + 1));

        // glitch on key2
        do_reset();
        key_i[2] = 1'b0;
        step(15);
        key_i[2] = 1'b1;
        step(60);
        chk("g_rises", 32'(rise_cnt[2]), 32'd0);
        chk("g_key_o", 32'(key_o), 32'h0);
        chk("g_nev", 32'(ev_k.size()), 32'd0);
        chk("g_ovf", 32'(overflow), 32'h0);

        // long press on key1
        do_reset();
        m = cyc;
        key_i[1] = 1'b0;
        step(150);
        m2 = cyc;
        key_i[1] = 1'b1;
        r = t_settle(m);
        f = t_settle(m2);
        step(f + 10 - cyc);
        chk("lp_nev", 32'(ev_k.size()), 32'd3);
        chk("lp_ev0", ev_word(0), w(1, 1));
        chk("lp_ev0_cyc", ev_cyc(0), 32'(r + 1));
        chk("lp_ev1", ev_word(1), w(1, 3));
        chk("lp_ev1_cyc", ev_cyc(1), 32'(r + 81));
        chk("lp_ev2", ev_word(2), w(1, 2));
        chk("lp_ev2_cyc", ev_cyc(2), 32'(f + 1));
        chk("lp_key_o", 32'(key_o), 32'h0);

        // all keys together, then all released (order also shows pointer back at 0)
        do_reset();
        m = cyc;
        key_i = 4'h0;
        r = t_settle(m);
        step(r + 10 - cyc);
        chk("s_key_o", 32'(key_o), 32'hF);
        for (int k = 0; k < 4; k++) chk($sformatf("s_rise%0d", k), 32'(rise_cyc[k]), 32'(r));
        m2 = cyc;
        key_i = 4'hF;
        f = t_settle(m2);
        step(f + 10 - cyc);
        chk("s_nev", 32'(ev_k.size()), 32'd8);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s_p%0d", i), ev_word(i), w(i, 1));
            chk($sformatf("s_p%0d_cyc", i), ev_cyc(i), 32'(r + 1 + i));
            chk($sformatf("s_r%0d", i), ev_word(4 + i), w(i, 2));
            chk($sformatf("s_r%0d_cyc", i), ev_cyc(4 + i), 32'(f + 1 + i));
        end

        // backpressure and overflow on key0
        do_reset();
        evt_ready = 1'b0;
        for (int p = 0; p < 6; p++) begin
            key_i[0] = (p % 2 == 0) ? 1'b0 : 1'b1;
            step(40);
            if (p == 1) chk("bp_head1", 32'({evt_key, evt_type}), w(0, 1));
            if (p == 4) begin
                chk("bp_ovf_before", 32'(overflow), 32'h0);
                chk("bp_head4", 32'({evt_key, evt_type}), w(0, 1));
            end
        end
        chk("bp_ovf", 32'(overflow), 32'h1);
        chk("bp_valid", 32'(evt_valid), 32'h1);
        chk("bp_head", 32'({evt_key, evt_type}), w(0, 1));
        evt_ready = 1'b1;
        step(20);
        chk("bp_nev", 32'(ev_k.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("bp_ev%0d", i), ev_word(i), w(0, (i % 2 == 0) ? 1 : 2));
        chk("bp_empty", 32'(evt_valid), 32'h0);
        chk("bp_ovf_kept", 32'(overflow), 32'h1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("bp_ovf_clr", 32'(overflow), 32'h0);

        // asynchronous reset with events queued and key1 held
        do_reset();
        evt_ready = 1'b0;
        key_i = 4'b1100;
        step(50);
        chk("ar_valid_pre", 32'(evt_valid), 32'h1);
        chk("ar_key_o_pre", 32'(key_o), 32'h3);
        key_i[0] = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(evt_valid), 32'h0);
        chk("ar_key_o", 32'(key_o), 32'h0);
        evt_ready = 1'b1;
        clear_mon();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(40);
        chk("ar_nev", 32'(ev_k.size()), 32'd1);
        chk("ar_ev0", ev_word(0), w(1, 1));
        chk("ar_ev0_cyc", ev_cyc(0), 32'(t_settle(0) + 1));
        chk("ar_key_o_post", 32'(key_o), 32'h2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
